// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Upstream feeder for the CPU boot-load port. A program of DEPTH bytes arrives
// on a valid/ready byte stream and is captured into a shadow array. While the
// CPU is held in boot-load, the byte at boot_addr is presented on boot_data,
// and the CPU memory writes it on every clock. Optionally every location is
// read back and compared before BootLoad is released and the CPU runs.
//
// Parameters
//   DEPTH   program bytes per load (CPU boot-load span)
//   ADDR_W  address width, 2**ADDR_W == DEPTH
//   VERIFY  1 = read-back check after the load, 0 = skip it
//
// Ports
//   clk        in   system clock shared with the CPU, rising edge
//   reset      in   asynchronous, active-low; clears all state
//   start      in   single-cycle load request (IDLE/RUN/ERROR only)
//   in_data    in   program byte
//   in_valid   in   in_data valid
//   in_ready   out  a byte is accepted this cycle when in_valid is high
//   boot_load  out  CPU BootLoad
//   boot_addr  out  CPU BootLoadAddress
//   boot_data  out  CPU WriteToMemory, shadow[boot_addr]
//   mem_rdata  in   CPU ReadFromMemory
//   done       out  program loaded (and verified), CPU running
//   error      out  read-back mismatch seen
//   err_addr   out  first mismatching address
// -----------------------------------------------------------------------------
module boot_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int VERIFY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              boot_load,
    output logic [ADDR_W-1:0] boot_addr,
    output logic [7:0]        boot_data,
    input  logic [7:0]        mem_rdata,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] FLUSH = 3'd2;
    localparam logic [2:0] SET   = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] RUN   = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [7:0]        shadow [DEPTH];

    // Outputs decode the registered state only, so nothing on the input side
    // reaches in_ready or boot_load combinationally.
    assign in_ready  = (state == LOAD);
    assign boot_load = (state != RUN);
    assign done      = (state == RUN);
    assign error     = (state == ERROR);
    assign boot_data = shadow[boot_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            boot_addr <= '0;
            err_addr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, RUN, ERROR: begin
                    if (start) begin
                        state <= LOAD;
                        cnt   <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        shadow[cnt] <= in_data;
                        // The new byte is presented next cycle and written
                        // into CPU memory at the following edge.
                        boot_addr   <= cnt;
                        if (cnt == LAST_ADDR) begin
                            state <= FLUSH;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Lets the write of the last byte land before moving on.
                    if (VERIFY != 0) begin
                        state     <= SET;
                        boot_addr <= '0;
                    end else begin
                        state <= RUN;
                    end
                end
                SET: begin
                    // Address is held a full cycle so mem_rdata is settled
                    // when CHECK samples it.
                    state <= CHECK;
                end
                CHECK: begin
                    if (mem_rdata != shadow[boot_addr]) begin
                        state    <= ERROR;
                        err_addr <= boot_addr;
                    end else if (boot_addr == LAST_ADDR) begin
                        state <= RUN;
                    end else begin
                        boot_addr <= boot_addr + 1'b1;
                        state     <= SET;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    logic       clk = 1'b0;
    logic       rstN;
    logic       start;
    logic [7:0] inData;
    logic       inValid;

    logic       inReady1, bootLoad1, done1, error1;
    logic [3:0] bootAddr1, errAddr1;
    logic [7:0] bootData1, memRdata1;

    logic       inReady0, bootLoad0, done0, error0;
    logic [3:0] bootAddr0, errAddr0;
    logic [7:0] bootData0, memRdata0;

    logic [7:0] mem1 [16];
    logic [7:0] mem0 [16];
    logic [7:0] prog [16];
    logic       corrEn;
    logic [3:0] corrAddr;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boot_loader #(.DEPTH(16), .ADDR_W(4), .VERIFY(1)) dut (
        .clk(clk), .reset(rstN), .start(start), .in_data(inData),
        .in_valid(inValid), .in_ready(inReady1), .boot_load(bootLoad1),
        .boot_addr(bootAddr1), .boot_data(bootData1), .mem_rdata(memRdata1),
        .done(done1), .error(error1), .err_addr(errAddr1)
    );

    boot_loader #(.DEPTH(16), .ADDR_W(4), .VERIFY(0)) dut0 (
        .clk(clk), .reset(rstN), .start(start), .in_data(inData),
        .in_valid(inValid), .in_ready(inReady0), .boot_load(bootLoad0),
        .boot_addr(bootAddr0), .boot_data(bootData0), .mem_rdata(memRdata0),
        .done(done0), .error(error0), .err_addr(errAddr0)
    );

    // CPU memory models: write on every edge while BootLoad is high,
    // combinational read; mem1 optionally returns a corrupted byte.
    always @(posedge clk) begin
        if (bootLoad1) mem1[bootAddr1] <= bootData1;
        if (bootLoad0) mem0[bootAddr0] <= bootData0;
    end
    assign memRdata1 = (corrEn && bootAddr1 == corrAddr) ? ~mem1[bootAddr1] : mem1[bootAddr1];
    assign memRdata0 = mem0[bootAddr0];

    typedef struct {
        logic [7:0] base;
        int         gap;
        bit         doRst;
        bit         vws;
        bit         cEn;
        int         cAddr;
        bit         expErr;
        int         expCyc1;
        int         expCyc0;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rstN = 1'b0;
        #2;
        chk("rst_bootload", 32'(bootLoad1), 1);
        chk("rst_addr", 32'(bootAddr1), 0);
        chk("rst_data", 32'(bootData1), 0);
        tick();
        rstN = 1'b1;
        tick();
    endtask

    // One complete load; expectations come from the stream/timing rules:
    // done (VERIFY=1) 2+2*16 cycles after the last accept, done (VERIFY=0)
    // 2 cycles after, error 4+2*addr cycles after.
    task automatic runLoad(input int gap, input bit vws, input bit cEn, input int cAddr,
                           input bit expErr, input int expCyc1, input int expCyc0);
        int  e0, idx, lastAcc, guard, d1, d0, early, m1, m0;
        bit  acc, seen1, seen0;
        corrEn   = cEn;
        corrAddr = cAddr[3:0];
        chk("ready_before_start", 32'(inReady1), 0);
        start = 1'b1;
        if (vws) begin
            inValid = 1'b1;
            inData  = 8'h55;
        end
        tick();
        start   = 1'b0;
        inValid = 1'b0;
        e0 = cyc;
        chk("load_bootload", 32'(bootLoad1), 1);
        chk("load_done", 32'(done1), 0);
        chk("load_error", 32'(error1), 0);
        chk("load_ready", 32'(inReady1), 1);
        chk("load_bootload0", 32'(bootLoad0), 1);
        idx = 0; lastAcc = 0; guard = 0;
        while (idx < 16 && guard < 1000) begin
            guard++;
            inValid = (int'($urandom_range(99)) >= gap);
            inData  = prog[idx];
            acc     = inValid && inReady1;
            tick();
            if (acc) begin
                idx++;
                lastAcc = cyc - e0;
            end
        end
        inValid = 1'b0;
        chk("accepted", 32'(idx), 16);
        seen1 = 0; seen0 = 0; d1 = 0; d0 = 0; early = 0;
        for (int t = 0; t < 300 && !(seen1 && seen0); t++) begin
            tick();
            if (!seen0 && done0) begin seen0 = 1; d0 = cyc - e0 + 1; end
            if (!seen1 && (done1 || error1)) begin seen1 = 1; d1 = cyc - e0 + 1; end
            if (!seen1 && !bootLoad1) early++;
        end
        chk("finish_seen1", 32'(seen1), 1);
        chk("finish_seen0", 32'(seen0), 1);
        chk("bootload_held", 32'(early), 0);
        chk("error", 32'(error1), 32'(expErr));
        if (expErr) begin
            chk("err_addr", 32'(errAddr1), 32'(cAddr));
            chk("err_bootload", 32'(bootLoad1), 1);
            chk("err_done", 32'(done1), 0);
            chk("err_cycle", 32'(d1 - lastAcc), 32'(4 + 2 * cAddr));
        end else begin
            chk("done", 32'(done1), 1);
            chk("run_bootload", 32'(bootLoad1), 0);
            chk("done_after_last", 32'(d1 - lastAcc), 34);
        end
        if (expCyc1 != 0) chk("abs_cycle1", 32'(d1), 32'(expCyc1));
        if (expCyc0 != 0) chk("abs_cycle0", 32'(d0), 32'(expCyc0));
        chk("done0", 32'(done0), 1);
        chk("run_bootload0", 32'(bootLoad0), 0);
        chk("done0_after_last", 32'(d0 - lastAcc), 2);
        m1 = 0; m0 = 0;
        for (int i = 0; i < 16; i++) begin
            if (mem1[i] !== prog[i]) m1++;
            if (mem0[i] !== prog[i]) m0++;
        end
        chk("mem1_contents", 32'(m1), 0);
        chk("mem0_contents", 32'(m0), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   n;
        vecs[0] = '{base: 8'h10, gap: 0,  doRst: 0, vws: 0, cEn: 0, cAddr: 0, expErr: 0, expCyc1: 50, expCyc0: 18};
        vecs[1] = '{base: 8'h10, gap: 40, doRst: 0, vws: 0, cEn: 0, cAddr: 0, expErr: 0, expCyc1: 0,  expCyc0: 0};
        vecs[2] = '{base: 8'h10, gap: 0,  doRst: 0, vws: 0, cEn: 1, cAddr: 7, expErr: 1, expCyc1: 34, expCyc0: 18};
        vecs[3] = '{base: 8'h30, gap: 0,  doRst: 0, vws: 0, cEn: 0, cAddr: 0, expErr: 0, expCyc1: 50, expCyc0: 18};
        vecs[4] = '{base: 8'hA0, gap: 0,  doRst: 1, vws: 1, cEn: 0, cAddr: 0, expErr: 0, expCyc1: 50, expCyc0: 18};

        rstN = 1'b0; start = 1'b0; inValid = 1'b0; inData = 8'h00;
        corrEn = 1'b0; corrAddr = 4'd0;
        tick(); tick();
        chk("reset_bootload", 32'(bootLoad1), 1);
        chk("reset_ready", 32'(inReady1), 0);
        chk("reset_done", 32'(done1), 0);
        chk("reset_error", 32'(error1), 0);
        chk("reset_addr", 32'(bootAddr1), 0);
        chk("reset_erraddr", 32'(errAddr1), 0);
        rstN = 1'b1;
        tick(); tick();
        chk("idle_bootload", 32'(bootLoad1), 1);
        chk("idle_ready", 32'(inReady1), 0);
        chk("idle_done", 32'(done1), 0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 16; i++) prog[i] = vecs[v].base + 8'(i);
            if (vecs[v].doRst) doReset();
            runLoad(vecs[v].gap, vecs[v].vws, vecs[v].cEn, vecs[v].cAddr,
                    vecs[v].expErr, vecs[v].expCyc1, vecs[v].expCyc0);
        end

        // Reset pulsed right after byte 5 is accepted.
        for (int i = 0; i < 16; i++) prog[i] = 8'hC0 + 8'(i);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int g = 0; g < 50 && n < 6; g++) begin
            inValid = 1'b1;
            inData  = prog[n];
            tick();
            n++;
        end
        inValid = 1'b0;
        chk("midload_addr_before", 32'(bootAddr1), 5);
        rstN = 1'b0;
        #2;
        chk("midrst_bootload", 32'(bootLoad1), 1);
        chk("midrst_ready", 32'(inReady1), 0);
        chk("midrst_addr", 32'(bootAddr1), 0);
        chk("midrst_shadow0", 32'(bootData1), 0);
        chk("midrst_done", 32'(done1), 0);
        tick();
        rstN = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) prog[i] = 8'h60 + 8'(i);
        runLoad(0, 0, 0, 0, 0, 50, 18);

        // Randomized loads against the rule-based expectations.
        for (int r = 0; r < 6; r++) begin
            bit ce;
            int ca;
            for (int i = 0; i < 16; i++) prog[i] = 8'($urandom);
            ce = bit'($urandom_range(1));
            ca = int'($urandom_range(15));
            runLoad(int'($urandom_range(60)), 0, ce, ca, ce, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Upstream feeder for the CPU's boot-load port. Accepts a 16-byte program as a valid/ready byte stream (from the host receiver). While holding the CPU in boot-load, it writes each byte into CPU memory through the BootLoad, BootLoadAddress and WriteToMemory inputs. It can optionally read every location back through ReadFromMemory, then releases BootLoad so the CPU runs.

## Interface
- DEPTH, 16: program bytes per load; equals CPU memory boot-load span.
- ADDR_W, 4: width of boot_addr; 2**ADDR_W == DEPTH.
- VERIFY, 1: 1 = read-back check after load; 0 = skip.

- clk  in  1  system clock, same clk as CPU; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- start  in  1  single-cycle request to begin a load.
- in_data  in  8  program byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- boot_load  out  1  drives CPU BootLoad.
- boot_addr  out  ADDR_W  drives CPU BootLoadAddress.
- boot_data  out  8  drives CPU WriteToMemory.
- mem_rdata  in  8  from CPU ReadFromMemory.
- done  out  1  program loaded (and verified); CPU running.
- error  out  1  verify mismatch.
- err_addr  out  ADDR_W  first mismatching address.

## Operation
- Shadow array: DEPTH x 8 registers, reset to 0.
- boot_data = shadow[boot_addr], combinational. CPU memory writes boot_data at boot_addr on every clk while boot_load=1, so all rewrites are idempotent.
- States:
  - IDLE: boot_load=1, in_ready=0. start -> LOAD; cnt=0.
  - LOAD: in_ready=1. Each accept (in_valid & in_ready) writes in_data to shadow[cnt], sets boot_addr<=cnt and increments cnt. Accept of byte DEPTH-1 -> FLUSH.
  - FLUSH: one cycle, in_ready=0, so the last write lands. Next state is VERIFY (boot_addr<=0) when VERIFY=1, else RUN.
  - VERIFY: two cycles per address, SET then CHECK.
    - CHECK compares mem_rdata with shadow[boot_addr].
    - Mismatch -> ERROR; err_addr<=boot_addr.
    - Match at DEPTH-1 -> RUN; otherwise boot_addr+1 -> SET.
  - RUN: boot_load=0, done=1. start -> LOAD; boot_load rises next cycle and done clears.
  - ERROR: boot_load=1, error=1. start -> LOAD; error clears.
- start is ignored in LOAD, FLUSH and VERIFY.
- cnt and boot_addr are ADDR_W bits wide and never wrap inside one load.
- Reset values: state=IDLE, boot_load=1, in_ready=0, boot_addr=0, boot_data=0, done=0, error=0, err_addr=0, cnt=0.
- Reset asserted mid-load or mid-run returns to IDLE at once. The shadow clears and the CPU is held in boot-load.

## Timing
- in_ready and boot_load are decoded from the registered state only; no input-to-output combinational path.
- start sampled at edge 0: LOAD from cycle 1. Back-to-back bytes are accepted in cycles 1..16, FLUSH is cycle 17, and VERIFY runs cycles 18..49.
- boot_load falls and done rises at cycle 50 (VERIFY=1) or cycle 18 (VERIFY=0).
- Gaps in in_valid stall LOAD indefinitely; no timeout.
- mem_rdata is sampled in CHECK only, one full cycle after boot_addr settles in SET.
- A byte accepted at edge N appears on boot_addr/boot_data during cycle N+1 and is written at edge N+1.

## Test plan
- Reset with start=0 -> boot_load=1, in_ready=0, done=0, error=0, boot_addr=0.
- start, then bytes 0x10..0x1F back-to-back with a matching memory model -> memory holds 0x10..0x1F, boot_load falls at cycle 50, done=1.
- Same stream with random in_valid gaps -> identical memory contents; done rises exactly 34 cycles after the last accept.
- Memory model corrupts address 7 -> error=1, err_addr=7, boot_load stays 1. A new start reloads, clears error and ends in done=1.
- reset pulsed after byte 5 -> immediate IDLE, boot_load=1, shadow zero; a fresh load of 16 bytes completes normally.
- VERIFY=0 with bytes 0xA0..0xAF -> done at cycle 18. start and in_valid asserted together in IDLE -> no byte accepted that cycle.
